// File: rtl/servo_aim_ctrl.sv
// servo_aim_ctrl: per-frame dead-banded proportional pan/tilt aiming with homing and glitch-free 50 Hz servo PWM
module servo_aim_ctrl #(
  parameter int CX         = 320,
  parameter int CY         = 240,
  parameter int DEADBAND   = 8,
  parameter int GAIN_SHIFT = 3,
  parameter int MAX_STEP   = 16,
  parameter int HOME_STEP  = 4,
  parameter int POS_MIN    = 0,
  parameter int POS_MAX    = 1000,
  parameter int POS_HOME   = 500,
  parameter int PERIOD     = 500_000,
  parameter int PULSE_MIN  = 25_000,
  parameter int PULSE_LSB  = 25,
  parameter int INV_PAN    = 0,
  parameter int INV_TILT   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       v_sync,
  input  logic [9:0] aim_x,
  input  logic [9:0] aim_y,
  input  logic       aim_detected,
  input  logic       target_off,
  output logic       pan_pwm,
  output logic       tilt_pwm,
  output logic [9:0] pan_pos,
  output logic [9:0] tilt_pos,
  output logic       homing,
  output logic       at_home
);
  localparam logic signed [10:0] DB   = 11'(DEADBAND);
  localparam logic signed [10:0] MS   = 11'(MAX_STEP);
  localparam logic signed [11:0] LO   = 12'(POS_MIN);
  localparam logic signed [11:0] HI   = 12'(POS_MAX);
  localparam logic        [9:0]  HM   = 10'(POS_HOME);
  localparam logic        [9:0]  HS   = 10'(HOME_STEP);
  localparam logic        [18:0] LAST = 19'(PERIOD - 1);
  localparam logic        [18:0] PW0  = 19'(PULSE_MIN);
  localparam logic        [18:0] PWL  = 19'(PULSE_LSB);
  typedef enum logic [1:0] {IDLE, TRACK, HOME} state_t;
  function automatic logic signed [11:0] step(input logic [9:0] aim, input logic [10:0] c, input logic inv);
    logic signed [10:0] e;
    logic signed [10:0] s;
    e = $signed({1'b0, aim}) - $signed(c);
    e = inv ? -e : e;
    s = e >>> GAIN_SHIFT;
    s = (e <= DB && e >= -DB) ? 11'sd0 : s > MS ? MS : s < -MS ? -MS : s;
    return {s[10], s};
  endfunction
  function automatic logic [9:0] sat(input logic [9:0] p, input logic signed [11:0] d);
    logic signed [11:0] n;
    n = $signed({2'b00, p}) + d;
    return n < LO ? LO[9:0] : n > HI ? HI[9:0] : n[9:0];
  endfunction
  function automatic logic [9:0] toward_home(input logic [9:0] p);
    return p > HM ? (p - HM > HS ? p - HS : HM) : (HM - p > HS ? p + HS : HM);
  endfunction
  state_t      state_q, state_d;
  logic        vs_d_q, frame_upd_q, homing_q;
  logic [9:0]  pan_q, pan_d, tilt_q, tilt_d;
  logic [9:0]  pan_trk, tilt_trk;
  logic [18:0] count_q, pan_lat_q, tilt_lat_q;
  logic        pan_pwm_q, tilt_pwm_q;
  logic        trk;
  assign trk      = frame_upd_q & aim_detected;
  assign pan_trk  = sat(pan_q, step(aim_x, 11'(CX), INV_PAN != 0));
  assign tilt_trk = sat(tilt_q, step(aim_y, 11'(CY), INV_TILT != 0));
  assign at_home  = (pan_q == HM) & (tilt_q == HM);
  assign pan_pos  = pan_q;
  assign tilt_pos = tilt_q;
  assign homing   = homing_q;
  assign pan_pwm  = pan_pwm_q;
  assign tilt_pwm = tilt_pwm_q;
  always_comb begin
    state_d = state_q;
    pan_d   = pan_q;
    tilt_d  = tilt_q;
    case (state_q)
      IDLE: begin
        if (trk) begin
          state_d = TRACK;
          pan_d   = pan_trk;
          tilt_d  = tilt_trk;
        end else if (target_off && !at_home) state_d = HOME;
      end
      TRACK: begin
        if (target_off) state_d = HOME;
        else if (trk) begin
          pan_d  = pan_trk;
          tilt_d = tilt_trk;
        end
      end
      HOME: begin
        if (trk) begin
          state_d = TRACK;
          pan_d   = pan_trk;
          tilt_d  = tilt_trk;
        end else if (at_home) state_d = IDLE;
        else if (frame_upd_q) begin
          pan_d  = toward_home(pan_q);
          tilt_d = toward_home(tilt_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      vs_d_q      <= 1'b0;
      frame_upd_q <= 1'b0;
      homing_q    <= 1'b0;
      pan_q       <= HM;
      tilt_q      <= HM;
      count_q     <= '0;
      pan_lat_q   <= PW0 + 19'(HM) * PWL;
      tilt_lat_q  <= PW0 + 19'(HM) * PWL;
      pan_pwm_q   <= 1'b0;
      tilt_pwm_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_d_q      <= v_sync;
      frame_upd_q <= v_sync & ~vs_d_q;
      homing_q    <= state_d == HOME;
      pan_q       <= pan_d;
      tilt_q      <= tilt_d;
      count_q     <= count_q == LAST ? '0 : count_q + 19'd1;
      pan_lat_q   <= count_q == LAST ? PW0 + 19'(pan_q) * PWL : pan_lat_q;
      tilt_lat_q  <= count_q == LAST ? PW0 + 19'(tilt_q) * PWL : tilt_lat_q;
      pan_pwm_q   <= count_q < pan_lat_q;
      tilt_pwm_q  <= count_q < tilt_lat_q;
    end
  end
endmodule

// File: tb/tb_servo_aim_ctrl.sv
// tb_servo_aim_ctrl: scoreboard bench for aiming, clamping, homing and PWM timing of servo_aim_ctrl
module tb_servo_aim_ctrl;
  localparam int P = 2000;
  localparam int PMIN = 100;
  localparam int M_TRK = 0;
  localparam int M_HOLD = 1;
  localparam int M_HOME = 2;
  typedef struct {int pan; int tilt;} exp_t;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       v_sync = 1'b0;
  logic       aim_detected = 1'b0;
  logic       target_off = 1'b0;
  logic [9:0] aim_x = '0;
  logic [9:0] aim_y = '0;
  logic       pan_pwm, tilt_pwm, homing, at_home;
  logic [9:0] pan_pos, tilt_pos;
  int         checks = 0;
  int         errors = 0;
  int         pan_m = 500;
  int         tilt_m = 500;
  exp_t       sb[$];
  always #5 clk = ~clk;
  servo_aim_ctrl #(.PERIOD(P), .PULSE_MIN(PMIN), .PULSE_LSB(1)) dut (
    .clk(clk), .reset(reset), .v_sync(v_sync), .aim_x(aim_x), .aim_y(aim_y),
    .aim_detected(aim_detected), .target_off(target_off), .pan_pwm(pan_pwm),
    .tilt_pwm(tilt_pwm), .pan_pos(pan_pos), .tilt_pos(tilt_pos), .homing(homing),
    .at_home(at_home)
  );
  function automatic int m_step(int aim, int c, bit inv);
    int e, s;
    e = inv ? c - aim : aim - c;
    if (e >= -8 && e <= 8) return 0;
    s = e >= 0 ? e / 8 : -((7 - e) / 8);
    return s > 16 ? 16 : s < -16 ? -16 : s;
  endfunction
  function automatic int m_sat(int p);
    return p < 0 ? 0 : p > 1000 ? 1000 : p;
  endfunction
  function automatic int m_home(int p);
    if (p > 500) return p - ((p - 500) < 4 ? p - 500 : 4);
    return p + ((500 - p) < 4 ? 500 - p : 4);
  endfunction
  task automatic frame(input int ax, input int ay, input int mode);
    exp_t e;
    int op, ot;
    op = pan_m;
    ot = tilt_m;
    aim_x = 10'(ax);
    aim_y = 10'(ay);
    aim_detected = (mode == M_TRK);
    if (mode == M_TRK) begin
      pan_m = m_sat(pan_m + m_step(ax, 320, 1'b0));
      tilt_m = m_sat(tilt_m + m_step(ay, 240, 1'b1));
    end else if (mode == M_HOME) begin
      pan_m = m_home(pan_m);
      tilt_m = m_home(tilt_m);
    end
    sb.push_back('{pan_m, tilt_m});
    @(negedge clk) v_sync = 1'b1;
    @(negedge clk) v_sync = 1'b0;
    checks++;
    if (pan_pos !== 10'(op) || tilt_pos !== 10'(ot)) begin
      errors++;
      $display("FAIL frame_latency: pos %0d/%0d, expected still %0d/%0d", pan_pos, tilt_pos, op, ot);
    end
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (pan_pos !== 10'(e.pan) || tilt_pos !== 10'(e.tilt)) begin
      errors++;
      $display("FAIL frame_pos: pos %0d/%0d, expected %0d/%0d", pan_pos, tilt_pos, e.pan, e.tilt);
    end
  endtask
  task automatic sync_rise();
    int n = 0;
    while (pan_pwm === 1'b1 && n < 3 * P) begin @(negedge clk); n++; end
    while (pan_pwm !== 1'b1 && n < 3 * P) begin @(negedge clk); n++; end
    if (n >= 3 * P) begin
      checks++;
      errors++;
      $display("FAIL sync_rise: no pan_pwm rise within %0d cycles", 3 * P);
    end
  endtask
  task automatic measure(output int ph, output int th, output int per);
    logic prev;
    per = 1;
    ph = (pan_pwm === 1'b1) ? 1 : 0;
    th = (tilt_pwm === 1'b1) ? 1 : 0;
    prev = pan_pwm;
    while (per < 3 * P) begin
      @(negedge clk);
      if (pan_pwm === 1'b1 && prev !== 1'b1) break;
      prev = pan_pwm;
      per++;
      if (pan_pwm === 1'b1) ph++;
      if (tilt_pwm === 1'b1) th++;
    end
  endtask
  task automatic check_pwm(input string name, input int ep, input int et);
    int ph, th, per;
    sync_rise();
    measure(ph, th, per);
    checks++;
    if (ph != ep || th != et || per != P) begin
      errors++;
      $display("FAIL %s: pan_hi=%0d tilt_hi=%0d period=%0d, expected %0d/%0d/%0d", name, ph, th, per, ep, et, P);
    end
  endtask
  task automatic test_reset();
    int ph, th, per;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (pan_pos !== 10'd500 || tilt_pos !== 10'd500 || at_home !== 1'b1 || homing !== 1'b0 || pan_pwm !== 1'b0 || tilt_pwm !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pos %0d/%0d at_home=%b homing=%b pwm=%b%b, expected 500/500 1 0 00", pan_pos, tilt_pos, at_home, homing, pan_pwm, tilt_pwm);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (pan_pwm !== 1'b1 || tilt_pwm !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_high: pwm=%b%b, expected 11", pan_pwm, tilt_pwm);
    end
    measure(ph, th, per);
    checks++;
    if (ph != PMIN + 500 || th != PMIN + 500 || per != P) begin
      errors++;
      $display("FAIL reset_period: pan_hi=%0d tilt_hi=%0d period=%0d, expected %0d/%0d/%0d", ph, th, per, PMIN + 500, PMIN + 500, P);
    end
  endtask
  task automatic test_track();
    frame(400, 240, M_TRK);
    check_pwm("track_pwm", PMIN + 510, PMIN + 500);
  endtask
  task automatic test_deadband_hold();
    frame(326, 246, M_TRK);
    frame(639, 479, M_HOLD);
    frame(639, 479, M_HOLD);
    checks++;
    if (homing !== 1'b0) begin
      errors++;
      $display("FAIL hold_homing: homing=%b, expected 0", homing);
    end
    frame(400, 240, M_TRK);
  endtask
  task automatic test_clamp();
    for (int i = 0; i < 40; i++) frame(639, 479, M_TRK);
    checks++;
    if (pan_pos !== 10'd1000 || tilt_pos !== 10'd0) begin
      errors++;
      $display("FAIL clamp_sat: pos %0d/%0d, expected 1000/0", pan_pos, tilt_pos);
    end
    check_pwm("clamp_pwm", PMIN + 1000, PMIN);
  endtask
  task automatic test_reset_mid();
    repeat (300) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (pan_pos !== 10'd500 || tilt_pos !== 10'd500 || at_home !== 1'b1 || pan_pwm !== 1'b0 || tilt_pwm !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: pos %0d/%0d at_home=%b pwm=%b%b, expected 500/500 1 00", pan_pos, tilt_pos, at_home, pan_pwm, tilt_pwm);
    end
    pan_m = 500;
    tilt_m = 500;
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_homing();
    frame(400, 320, M_TRK);
    @(negedge clk) target_off = 1'b1;
    @(negedge clk);
    checks++;
    if (homing !== 1'b1) begin
      errors++;
      $display("FAIL homing_rise: homing=%b, expected 1", homing);
    end
    frame(0, 0, M_HOME);
    frame(0, 0, M_HOME);
    checks++;
    if (homing !== 1'b1 || at_home !== 1'b0) begin
      errors++;
      $display("FAIL homing_mid: homing=%b at_home=%b, expected 1 0", homing, at_home);
    end
    frame(0, 0, M_HOME);
    repeat (2) @(negedge clk);
    checks++;
    if (homing !== 1'b0 || at_home !== 1'b1) begin
      errors++;
      $display("FAIL homing_done: homing=%b at_home=%b, expected 0 1", homing, at_home);
    end
    target_off = 1'b0;
  endtask
  task automatic test_reacquire();
    frame(400, 320, M_TRK);
    @(negedge clk) target_off = 1'b1;
    @(negedge clk) target_off = 1'b0;
    frame(0, 0, M_HOME);
    frame(400, 240, M_TRK);
    checks++;
    if (homing !== 1'b0) begin
      errors++;
      $display("FAIL reacquire_homing: homing=%b, expected 0", homing);
    end
    frame(400, 240, M_HOLD);
  endtask
  task automatic test_off_priority();
    aim_x = 10'd400;
    aim_y = 10'd240;
    aim_detected = 1'b1;
    @(negedge clk) v_sync = 1'b1;
    @(negedge clk) begin v_sync = 1'b0; target_off = 1'b1; end
    @(negedge clk);
    checks++;
    if (pan_pos !== 10'(pan_m) || tilt_pos !== 10'(tilt_m) || homing !== 1'b1) begin
      errors++;
      $display("FAIL off_priority: pos %0d/%0d homing=%b, expected %0d/%0d 1", pan_pos, tilt_pos, homing, pan_m, tilt_m);
    end
    target_off = 1'b0;
    for (int i = 0; i < 4; i++) frame(0, 0, M_HOME);
    repeat (2) @(negedge clk);
    checks++;
    if (homing !== 1'b0 || at_home !== 1'b1) begin
      errors++;
      $display("FAIL off_priority_home: homing=%b at_home=%b, expected 0 1", homing, at_home);
    end
  endtask
  task automatic test_glitch_free();
    exp_t e;
    int hi, n;
    aim_x = 10'd400;
    aim_y = 10'd240;
    aim_detected = 1'b1;
    pan_m = m_sat(pan_m + m_step(400, 320, 1'b0));
    tilt_m = m_sat(tilt_m + m_step(240, 240, 1'b1));
    sb.push_back('{pan_m, tilt_m});
    sync_rise();
    hi = 1;
    n = 0;
    while (n < P) begin
      v_sync = (n == 100);
      @(negedge clk);
      n++;
      if (pan_pwm !== 1'b1) break;
      hi++;
    end
    v_sync = 1'b0;
    checks++;
    if (hi != PMIN + 500) begin
      errors++;
      $display("FAIL glitch_current: pan_hi=%0d, expected %0d", hi, PMIN + 500);
    end
    e = sb.pop_front();
    checks++;
    if (pan_pos !== 10'(e.pan) || tilt_pos !== 10'(e.tilt)) begin
      errors++;
      $display("FAIL glitch_pos: pos %0d/%0d, expected %0d/%0d", pan_pos, tilt_pos, e.pan, e.tilt);
    end
    check_pwm("glitch_next", PMIN + 510, PMIN + 500);
  endtask
  initial begin
    test_reset();
    test_track();
    test_deadband_hold();
    test_clamp();
    test_reset_mid();
    test_homing();
    test_reacquire();
    test_off_priority();
    test_glitch_free();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
